// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace debugger packet sink.
package trdb_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned SINK_FIFO_DEPTH   = 16;
    localparam int unsigned SINK_STALL_THRESH = 12;

    typedef enum logic [0:0] {
        SINK_IDLE = 1'b0,
        SINK_REQ  = 1'b1
    } sink_state_e;

    // Memory write payload held stable while a request is outstanding.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } sink_wr_t;

endpackage

// File: rtl/trdb_sync_fifo.sv
// Generic synchronous FIFO with flush.
//  clk, rst      : clock, asynchronous active-high reset
//  flush         : empty the FIFO at the next edge (dominates push/pop)
//  push, wdata   : enqueue (ignored when full unless popping in the same cycle)
//  pop           : dequeue head (ignored when empty)
//  head_c        : current head word (combinational read)
//  head_next_c   : entry behind the head, valid when count >= 2
//  full_c/empty_c: occupancy flags derived from count
//  count         : registered occupancy
module trdb_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head_c,
    output logic [DATA_WIDTH-1:0]   head_next_c,
    output logic                    full_c,
    output logic                    empty_c,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_c      = (count == CW'(DEPTH));
    assign empty_c     = (count == '0);
    assign pop_ok      = pop & ~empty_c;
    // A pop frees the slot this cycle, so a push at full is still accepted.
    assign push_ok     = push & (~full_c | pop_ok);
    assign head_c      = mem[rd_ptr];
    assign head_next_c = mem[rd_ptr + AW'(1)];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/trdb_packet_sink.sv
// Trace packet sink: buffers packet words in a FIFO and drains them one word
// per transfer into a circular buffer in memory over a req/gnt port.
//  clk_i, rst_i           : clock, asynchronous active-high reset
//  enable_i, flush_i      : sink enable, 1-cycle flush pulse
//  buf_base_i, buf_size_i : ring buffer base byte address and size in bytes
//  packet_word_i/_valid_i : incoming trace word stream (no ready)
//  stall_o                : upstream backpressure, FIFO nearly full
//  mem_req_o/addr/wdata   : memory write request, held until mem_gnt_i
//  overflow_o             : sticky, a word was dropped on a full FIFO
//  wrap_o                 : 1-cycle pulse when the write offset wraps to 0
//  offset_o               : current write offset in bytes
module trdb_packet_sink
    import trdb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = SINK_FIFO_DEPTH,
    parameter int unsigned STALL_THRESH = SINK_STALL_THRESH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] buf_base_i,
    input  logic [XLEN-1:0] buf_size_i,
    input  logic [XLEN-1:0] packet_word_i,
    input  logic            packet_word_valid_i,
    output logic            stall_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    output logic            overflow_o,
    output logic            wrap_o,
    output logic [XLEN-1:0] offset_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    sink_state_e     state, state_nxt;
    sink_wr_t        wr, wr_nxt;
    logic [XLEN-1:0] offset, offset_nxt;
    logic            flush_pending, flush_pending_nxt;
    logic            overflow, overflow_nxt;
    logic            stall, stall_nxt;
    logic            wrap, wrap_nxt;

    logic [XLEN-1:0] head_c;
    logic [XLEN-1:0] head_next_c;
    logic            full_c;
    logic            empty_c;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            pop;
    logic            push;
    logic            drop;
    logic            clear;
    logic            flush_win;
    logic            size_ok;
    logic [XLEN-1:0] offset_step;
    logic            wrap_hit;

    // Transfer handshake and FIFO qualifiers.
    assign pop         = (state == SINK_REQ) & mem_gnt_i;
    assign flush_win   = flush_i | flush_pending;
    assign push        = packet_word_valid_i & enable_i & ~flush_win & (~full_c | pop);
    assign drop        = packet_word_valid_i & enable_i & ~flush_win & full_c & ~pop;
    // In REQ the clear waits for the outstanding word to be granted.
    assign clear       = (flush_win & pop) | (flush_i & (state == SINK_IDLE));
    assign size_ok     = (buf_size_i >= XLEN'(4));
    assign offset_step = offset + XLEN'(4);
    assign wrap_hit    = (offset_step >= buf_size_i);
    assign count_nxt   = clear ? '0 : (count + CW'(push) - CW'(pop));
    assign stall_nxt   = (32'(count_nxt) >= STALL_THRESH);

    trdb_sync_fifo #(
        .DATA_WIDTH (XLEN),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .flush       (clear),
        .push        (push),
        .wdata       (packet_word_i),
        .pop         (pop),
        .head_c      (head_c),
        .head_next_c (head_next_c),
        .full_c      (full_c),
        .empty_c     (empty_c),
        .count       (count)
    );

    // Next-state, offset and status logic.
    always_comb begin
        state_nxt         = state;
        wr_nxt            = wr;
        offset_nxt        = offset;
        flush_pending_nxt = flush_pending;
        overflow_nxt      = overflow | drop;
        wrap_nxt          = 1'b0;

        if (pop) begin
            offset_nxt = wrap_hit ? '0 : offset_step;
            wrap_nxt   = wrap_hit;
        end

        case (state)
            SINK_IDLE: begin
                if (enable_i && !empty_c && size_ok && !flush_i) begin
                    state_nxt   = SINK_REQ;
                    wr_nxt.addr = buf_base_i + offset;
                    wr_nxt.data = head_c;
                end
            end
            SINK_REQ: begin
                if (flush_i && !pop) begin
                    flush_pending_nxt = 1'b1;
                end
                if (pop) begin
                    // Chain the next word without a bubble; a word pushed this
                    // cycle into a one-entry FIFO becomes the next head.
                    if (!flush_win && enable_i && size_ok &&
                        ((count >= CW'(2)) || push)) begin
                        wr_nxt.addr = buf_base_i + offset_nxt;
                        wr_nxt.data = (count >= CW'(2)) ? head_next_c : packet_word_i;
                    end else begin
                        state_nxt = SINK_IDLE;
                    end
                end
            end
            default: state_nxt = SINK_IDLE;
        endcase

        if (clear) begin
            offset_nxt        = '0;
            overflow_nxt      = 1'b0;
            flush_pending_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= SINK_IDLE;
            wr            <= '0;
            offset        <= '0;
            flush_pending <= 1'b0;
            overflow      <= 1'b0;
            stall         <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr            <= wr_nxt;
            offset        <= offset_nxt;
            flush_pending <= flush_pending_nxt;
            overflow      <= overflow_nxt;
            stall         <= stall_nxt;
            wrap          <= wrap_nxt;
        end
    end

    assign mem_req_o   = (state == SINK_REQ);
    assign mem_addr_o  = wr.addr;
    assign mem_wdata_o = wr.data;
    assign offset_o    = offset;
    assign overflow_o  = overflow;
    assign stall_o     = stall;
    assign wrap_o      = wrap;

endmodule
